// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the parametrised multicycle MIPS controller.
// Holds the 4-bit state encoding, the opcode and funct values the
// controller recognises, the ALU operation codes, and the select codes
// driven onto the alusrcb and pcsource datapath muxes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_LBRD    = 4'd3,
    S_LBWR    = 4'd4,
    S_SBWR    = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWR = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_JEX     = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWR  = 4'd12
  } state_t;

  // opcodes (IR[31:26])
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_CONST = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // next-PC select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational R-type funct decoder.
// Ports:
//   funct   - IR[5:0] of the current instruction
//   alucont - ALU operation for the decoded funct (add when unknown)
//   illegal - high when funct is not one of add/sub/and/or/slt
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       illegal
);

  always_comb begin
    alucont = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alucont = ALU_ADD;
      FN_SUB:  alucont = ALU_SUB;
      FN_AND:  alucont = ALU_AND;
      FN_OR:   alucont = ALU_OR;
      FN_SLT:  alucont = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl_param.sv
// Multicycle MIPS controller for 8/16/32-bit datapaths.
// The 32-bit instruction is fetched in 32/WIDTH beats; every memory access
// (fetch beats, lb read, sb write) stalls until mem_ready. Supports lb, sb,
// R-type add/sub/and/or/slt, beq, bne, addi and j, and pulses illegal_op on
// anything else.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-low reset
//   op, funct, zero     - IR fields and ALU zero flag from the datapath
//   mem_ready           - memory completes the current access this cycle
//   memread/memwrite    - memory request strobes, iord selects the address
//   irwrite             - one-hot IR slice load enable (IR_BEATS bits)
//   alusrca/alusrcb/alucont - ALU operand selects and operation
//   pcsource/pcen       - next-PC select and PC write enable
//   regwrite/regdst/memtoreg - register file write controls
//   illegal_op          - one-cycle pulse on an unsupported op or funct
module mips_multicycle_ctrl_param
  import mips_ctrl_pkg::*;
#(
  parameter  int WIDTH    = 8,
  localparam int IR_BEATS = 32 / WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                memread,
  output logic                memwrite,
  output logic                iord,
  output logic [IR_BEATS-1:0] irwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [2:0]          alucont,
  output logic [1:0]          pcsource,
  output logic                pcen,
  output logic                regwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                illegal_op
);

  // a single-beat fetch still keeps a 1-bit (always zero) beat counter
  localparam int BEAT_W = (IR_BEATS > 1) ? $clog2(IR_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IR_BEATS - 1);

  state_t            state, nextstate;
  logic [BEAT_W-1:0] beat, nextbeat;
  logic [2:0]        rtype_alucont;
  logic              rtype_illegal;

  mips_alu_decoder u_alu_decoder (
    .funct   (funct),
    .alucont (rtype_alucont),
    .illegal (rtype_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
      beat  <= '0;
    end else begin
      state <= nextstate;
      beat  <= nextbeat;
    end
  end

  always_comb begin
    nextstate  = state;
    nextbeat   = beat;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = '0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    alucont    = ALU_ADD;
    pcsource   = PC_ALU;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_CONST;
        // a beat only retires (IR slice load + PC advance) when memory answers
        if (mem_ready) begin
          for (int i = 0; i < IR_BEATS; i++) begin
            irwrite[i] = (beat == BEAT_W'(i));
          end
          pcen = 1'b1;
          if (beat == LAST_BEAT) begin
            nextstate = S_DECODE;
            nextbeat  = '0;
          end else begin
            nextbeat = beat + BEAT_W'(1);
          end
        end
      end

      S_DECODE: begin
        // branch target is precomputed here while the op is dispatched
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LB, OP_SB: nextstate = S_MEMADR;
          OP_RTYPE:     nextstate = S_RTYPEEX;
          OP_BEQ:       nextstate = S_BEQEX;
          OP_BNE:       nextstate = S_BNEEX;
          OP_ADDI:      nextstate = S_ADDIEX;
          OP_J:         nextstate = S_JEX;
          default: begin
            illegal_op = 1'b1;
            nextstate  = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_IMM;
        nextstate = (op == OP_SB) ? S_SBWR : S_LBRD;
      end

      S_LBRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (mem_ready) nextstate = S_LBWR;
      end

      S_LBWR: begin
        regwrite  = 1'b1;
        memtoreg  = 1'b1;
        nextstate = S_FETCH;
      end

      S_SBWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) nextstate = S_FETCH;
      end

      S_RTYPEEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_B;
        alucont = rtype_alucont;
        if (rtype_illegal) begin
          illegal_op = 1'b1;
          nextstate  = S_FETCH;
        end else begin
          nextstate = S_RTYPEWR;
        end
      end

      S_RTYPEWR: begin
        regwrite  = 1'b1;
        regdst    = 1'b1;
        nextstate = S_FETCH;
      end

      S_BEQEX, S_BNEEX: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_B;
        alucont   = ALU_SUB;
        pcsource  = PC_ALUOUT;
        pcen      = (state == S_BEQEX) ? zero : ~zero;
        nextstate = S_FETCH;
      end

      S_JEX: begin
        pcsource  = PC_JUMP;
        pcen      = 1'b1;
        nextstate = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_IMM;
        nextstate = S_ADDIWR;
      end

      S_ADDIWR: begin
        regwrite  = 1'b1;
        nextstate = S_FETCH;
      end

      default: nextstate = S_FETCH;
    endcase

    // while reset is held no access, write or pulse may escape, even though
    // the Moore selects still reflect the current state
    if (!reset) begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      pcen       = 1'b0;
      irwrite    = '0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl_param.sv
// Self-checking bench for mips_multicycle_ctrl_param.
// Three instances (WIDTH 8/16/32) share the instruction inputs; only the
// selected one is out of reset at a time. Each instruction is expanded into
// the list of cycles it should take, and that list is walked against the DUT
// while mem_ready, zero and reset are driven directed or random.
module tb_mips_multicycle_ctrl_param;

  localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;

  typedef struct {
    logic       memread, memwrite, iord, alusrca, regwrite, regdst, memtoreg, illegal;
    logic [3:0] irwrite;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alucont;
    int         pcmode;   // 0 never, 1 always, 2 when zero, 3 when not zero
    bit         waitmem;  // cycle repeats until mem_ready
  } step_t;

  logic       clk = 1'b0;
  logic       rstn, zero, mem_ready;
  logic [5:0] op, funct;
  int         sel, nbeats, width;
  int         passed = 0, failed = 0, total = 0;
  step_t      q[$];

  logic       rstv [3];
  logic       mr [3], mw [3], io [3], asa [3], pce [3], rw [3], rd [3], m2r [3], ill [3];
  logic [1:0] asb [3], pcs [3];
  logic [2:0] alu [3];
  logic [3:0] irw8;
  logic [1:0] irw16;
  logic [0:0] irw32;
  logic [3:0] irwsel;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) rstv[i] = (sel == i) ? rstn : 1'b0;
    case (sel)
      0:       irwsel = irw8;
      1:       irwsel = {2'b00, irw16};
      default: irwsel = {3'b000, irw32};
    endcase
  end

  mips_multicycle_ctrl_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rstv[0]), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memread(mr[0]), .memwrite(mw[0]), .iord(io[0]), .irwrite(irw8), .alusrca(asa[0]),
    .alusrcb(asb[0]), .alucont(alu[0]), .pcsource(pcs[0]), .pcen(pce[0]), .regwrite(rw[0]),
    .regdst(rd[0]), .memtoreg(m2r[0]), .illegal_op(ill[0]));

  mips_multicycle_ctrl_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rstv[1]), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memread(mr[1]), .memwrite(mw[1]), .iord(io[1]), .irwrite(irw16), .alusrca(asa[1]),
    .alusrcb(asb[1]), .alucont(alu[1]), .pcsource(pcs[1]), .pcen(pce[1]), .regwrite(rw[1]),
    .regdst(rd[1]), .memtoreg(m2r[1]), .illegal_op(ill[1]));

  mips_multicycle_ctrl_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rstv[2]), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memread(mr[2]), .memwrite(mw[2]), .iord(io[2]), .irwrite(irw32), .alusrca(asa[2]),
    .alusrcb(asb[2]), .alucont(alu[2]), .pcsource(pcs[2]), .pcen(pce[2]), .regwrite(rw[2]),
    .regdst(rd[2]), .memtoreg(m2r[2]), .illegal_op(ill[2]));

  function automatic step_t blank();
    step_t s;
    s.memread = 0; s.memwrite = 0; s.iord = 0; s.alusrca = 0; s.regwrite = 0;
    s.regdst = 0; s.memtoreg = 0; s.illegal = 0; s.irwrite = 4'b0000;
    s.alusrcb = 2'b00; s.pcsource = 2'b00; s.alucont = 3'b010;
    s.pcmode = 0; s.waitmem = 0;
    return s;
  endfunction

  function automatic void functInfo(input logic [5:0] f, output bit known, output logic [2:0] a);
    known = 1'b1;
    case (f)
      6'b100000: a = 3'b010;
      6'b100010: a = 3'b110;
      6'b100100: a = 3'b000;
      6'b100101: a = 3'b001;
      6'b101010: a = 3'b111;
      default: begin known = 1'b0; a = 3'b010; end
    endcase
  endfunction

  // expand one instruction into its expected cycle list
  task automatic buildInstr(input logic [5:0] o, input logic [5:0] f);
    step_t s;
    bit known;
    logic [2:0] a;
    q.delete();
    for (int k = 0; k < nbeats; k++) begin
      s = blank(); s.memread = 1; s.alusrcb = 2'b01; s.irwrite = 4'(1 << k);
      s.pcmode = 1; s.waitmem = 1; q.push_back(s);
    end
    s = blank(); s.alusrcb = 2'b11;
    if (!(o inside {LB, SB, RT, BEQ, BNE, ADDI, JMP})) begin
      s.illegal = 1; q.push_back(s); return;
    end
    q.push_back(s);
    s = blank();
    if (o == LB || o == SB) begin
      s.alusrca = 1; s.alusrcb = 2'b10; q.push_back(s);
      s = blank(); s.iord = 1; s.waitmem = 1;
      if (o == LB) begin
        s.memread = 1; q.push_back(s);
        s = blank(); s.regwrite = 1; s.memtoreg = 1; q.push_back(s);
      end else begin
        s.memwrite = 1; q.push_back(s);
      end
    end else if (o == RT) begin
      functInfo(f, known, a);
      s.alusrca = 1; s.alucont = a;
      if (!known) begin s.illegal = 1; q.push_back(s); return; end
      q.push_back(s);
      s = blank(); s.regwrite = 1; s.regdst = 1; q.push_back(s);
    end else if (o == BEQ || o == BNE) begin
      s.alusrca = 1; s.alucont = 3'b110; s.pcsource = 2'b01;
      s.pcmode = (o == BEQ) ? 2 : 3; q.push_back(s);
    end else if (o == ADDI) begin
      s.alusrca = 1; s.alusrcb = 2'b10; q.push_back(s);
      s = blank(); s.regwrite = 1; q.push_back(s);
    end else begin
      s.pcsource = 2'b10; s.pcmode = 1; q.push_back(s);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic z, input logic rn);
    mem_ready = rdy;
    zero      = z;
    rstn      = rn;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkCycle(input int idx, input logic [5:0] o);
    step_t e;
    logic  pc;
    string t;
    e  = q[0];
    pc = (e.pcmode == 1) || (e.pcmode == 2 && zero) || (e.pcmode == 3 && !zero);
    if (e.waitmem && !mem_ready) begin pc = 0; e.irwrite = 4'b0000; end
    if (!rstn) begin
      e.memread = 0; e.memwrite = 0; e.regwrite = 0; e.irwrite = 4'b0000; e.illegal = 0; pc = 0;
    end
    t = $sformatf("w%0d op%06b step%0d", width, o, idx);
    checkOutput({t, " memread"},  8'(mr[sel]),  8'(e.memread));
    checkOutput({t, " memwrite"}, 8'(mw[sel]),  8'(e.memwrite));
    checkOutput({t, " iord"},     8'(io[sel]),  8'(e.iord));
    checkOutput({t, " irwrite"},  8'(irwsel),   8'(e.irwrite));
    checkOutput({t, " alusrca"},  8'(asa[sel]), 8'(e.alusrca));
    checkOutput({t, " alusrcb"},  8'(asb[sel]), 8'(e.alusrcb));
    checkOutput({t, " alucont"},  8'(alu[sel]), 8'(e.alucont));
    checkOutput({t, " pcsource"}, 8'(pcs[sel]), 8'(e.pcsource));
    checkOutput({t, " pcen"},     8'(pce[sel]), 8'(pc));
    checkOutput({t, " regwrite"}, 8'(rw[sel]),  8'(e.regwrite));
    checkOutput({t, " regdst"},   8'(rd[sel]),  8'(e.regdst));
    checkOutput({t, " memtoreg"}, 8'(m2r[sel]), 8'(e.memtoreg));
    checkOutput({t, " illegal"},  8'(ill[sel]), 8'(e.illegal));
  endtask

  // zmode: -1 random per cycle, else fixed; waitStep/waitLen: directed stall;
  // resetStep: drop reset for one cycle at that step (aborts the instruction)
  task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                          input int waitStep, input int waitLen, input int resetStep, input bit rnd);
    int   idx = 0, waited = 0, cyc = 0;
    logic rdy, z, rn;
    op = o; funct = f;
    buildInstr(o, f);
    while (q.size() > 0 && cyc < 300) begin
      rn = !(idx == resetStep);
      if (rnd) rdy = ($urandom_range(0, 9) < 7);
      else     rdy = !(idx == waitStep && waited < waitLen);
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : (zmode != 0);
      applyStimulus(rdy, z, rn);
      @(negedge clk);
      checkCycle(idx, o);
      @(posedge clk); #1;
      cyc++;
      if (!rn) q.delete();
      else if (q[0].waitmem && !rdy) begin
        if (idx == waitStep) waited++;
      end else begin
        void'(q.pop_front());
        idx++;
      end
    end
    if (q.size() != 0) begin
      total++; failed++;
      $error("[TB] FAIL budget w%0d op%06b: observed %0d steps left expected 0", width, o, q.size());
      q.delete();
    end
  endtask

  task automatic randomRun(input int count);
    logic [5:0] o, f;
    int         rs;
    for (int n = 0; n < count; n++) begin
      f = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 8))
        0: o = LB;   1: o = SB;   3: o = BEQ;  4: o = BNE;
        5: o = ADDI; 6: o = JMP;  7: o = 6'($urandom_range(0, 63));
        2: begin
          o = RT;
          case ($urandom_range(0, 4))
            0: f = 6'b100000; 1: f = 6'b100010; 2: f = 6'b100100;
            3: f = 6'b100101; default: f = 6'b101010;
          endcase
        end
        default: o = RT;
      endcase
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      runInstr(o, f, -1, -1, 0, rs, 1'b1);
    end
  endtask

  initial begin
    sel = 0; nbeats = 4; width = 8;
    op = 6'd0; funct = 6'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset memread",  8'(mr[0]),  8'h00);
    checkOutput("reset memwrite", 8'(mw[0]),  8'h00);
    checkOutput("reset regwrite", 8'(rw[0]),  8'h00);
    checkOutput("reset pcen",     8'(pce[0]), 8'h00);
    checkOutput("reset irwrite",  8'(irw8),   8'h00);
    checkOutput("reset illegal",  8'(ill[0]), 8'h00);
    checkOutput("reset alusrcb",  8'(asb[0]), 8'h01);
    @(posedge clk); #1;

    // WIDTH=8 directed
    runInstr(ADDI, 6'd0, 0, -1, 0, -1, 1'b0);
    runInstr(LB, 6'd0, 0, 6, 3, -1, 1'b0);
    runInstr(SB, 6'd0, 0, 6, 2, -1, 1'b0);
    runInstr(BEQ, 6'd0, 1, -1, 0, -1, 1'b0);
    runInstr(BEQ, 6'd0, 0, -1, 0, -1, 1'b0);
    runInstr(BNE, 6'd0, 0, -1, 0, -1, 1'b0);
    runInstr(BNE, 6'd0, 1, -1, 0, -1, 1'b0);
    runInstr(RT, 6'b101010, 0, -1, 0, -1, 1'b0);
    runInstr(RT, 6'b000111, 0, -1, 0, -1, 1'b0);
    runInstr(JMP, 6'd0, 0, -1, 0, -1, 1'b0);
    runInstr(SB, 6'd0, 0, 6, 1, 6, 1'b0);
    runInstr(6'b111111, 6'd0, 0, -1, 0, -1, 1'b0);
    runInstr(ADDI, 6'd0, 0, 2, 1, 2, 1'b0);
    runInstr(RT, 6'b100010, 0, -1, 0, -1, 1'b0);
    randomRun(150);

    // WIDTH=16
    sel = 1; nbeats = 2; width = 16;
    runInstr(ADDI, 6'd0, 0, 1, 2, -1, 1'b0);
    runInstr(LB, 6'd0, 0, -1, 0, -1, 1'b0);
    randomRun(120);

    // WIDTH=32
    sel = 2; nbeats = 1; width = 32;
    runInstr(JMP, 6'd0, 0, 0, 2, -1, 1'b0);
    runInstr(RT, 6'b100101, 0, -1, 0, -1, 1'b0);
    randomRun(120);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
